// File: rtl/bcd_countdown_pkg.sv
// rtl/bcd_countdown_pkg.sv - shared state encoding and BCD helpers for the countdown timer
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } bcd3_t;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Only ever applied to a non-zero value, so the hundreds digit cannot wrap.
    function automatic bcd3_t bcd_dec(input bcd3_t v);
        bcd3_t r;
        r = v;
        if (v.u != 4'd0) begin
            r.u = v.u - 4'd1;
        end else begin
            r.u = BCD_MAX;
            if (v.t != 4'd0) begin
                r.t = v.t - 4'd1;
            end else begin
                r.t = BCD_MAX;
                r.h = v.h - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_countdown_key_edge.sv
// rtl/bcd_countdown_key_edge.sv - key synchronizer, debouncer and press pulse generator
module key_edge #(
    parameter int DEB = 500000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEB > 1) ? $clog2(DEB + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_a  <= key_n;
            sync_b  <= sync_a;
            level_q <= level;
            press   <= level_q & ~level;
            // Any sample agreeing with the current level restarts the stability count.
            if (sync_b != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - settable 3-digit BCD countdown timer with start/pause key
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int M      = 5,
    parameter int DEB    = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        load,
    input  logic [11:0] preset,
    input  logic        key_n,
    output logic [3:0]  bcd_100,
    output logic [3:0]  bcd_10,
    output logic [3:0]  bcd_1,
    output logic        running,
    output logic        done
);

    localparam int CNT_MAX = CLK_HZ / M - 1;
    localparam int PW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CNT_MAX);

    state_t        state;
    bcd3_t         digits;
    bcd3_t         digits_dec;
    logic [PW-1:0] presc;
    logic          press;
    logic          tick;

    key_edge #(.DEB(DEB)) u_key (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .key_n    (key_n),
        .press    (press)
    );

    always_comb begin
        tick       = (state == ST_RUN) && (presc == PMAX);
        digits_dec = bcd_dec(digits);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            digits  <= '0;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= (state == ST_RUN);
            done    <= (state == ST_DONE);
            if (load) begin
                state  <= ST_IDLE;
                digits <= {sat_digit(preset[11:8]), sat_digit(preset[7:4]), sat_digit(preset[3:0])};
                presc  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            presc <= '0;
                            state <= (digits == '0) ? ST_DONE : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Reaching zero wins over a simultaneous pause request.
                        if (tick) begin
                            presc  <= '0;
                            digits <= digits_dec;
                            if (digits_dec == '0) begin
                                state <= ST_DONE;
                            end else if (press) begin
                                state <= ST_PAUSE;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                            if (press) begin
                                state <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (press) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (press) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bcd_100 = digits.h;
    assign bcd_10  = digits.t;
    assign bcd_1   = digits.u;

endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - scoreboard bench for bcd_countdown against a cycle-level reference model
module tb_bcd_countdown;

    localparam int CLK_HZ  = 10;
    localparam int M       = 1;
    localparam int DEB     = 2;
    localparam int CNT_MAX = CLK_HZ / M - 1;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [11:0] preset;
    logic        key_n;
    logic [3:0]  bcd_100;
    logic [3:0]  bcd_10;
    logic [3:0]  bcd_1;
    logic        running;
    logic        done;

    bcd_countdown #(.CLK_HZ(CLK_HZ), .M(M), .DEB(DEB)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .load     (load),
        .preset   (preset),
        .key_n    (key_n),
        .bcd_100  (bcd_100),
        .bcd_10   (bcd_10),
        .bcd_1    (bcd_1),
        .running  (running),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
    typedef struct {
        int val;
        bit run;
        bit dn;
    } exp_t;

    exp_t    exp_q[$];
    bit      hist[$];
    bit      m_deb;
    bit      m_fell;
    bit      m_press;
    int      m_val;
    int      m_ph;
    mstate_e m_st;
    int      m_tick_press;
    int      m_zero_hits;

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    // Reference: time-indexed key history, integer count value, phase counter for the tick rate.
    always @(posedge clk) begin
        exp_t    e;
        bit      p;
        bit      all_diff;
        mstate_e old_st;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
            m_deb = 1'b1; m_fell = 1'b0; m_press = 1'b0;
            m_val = 0; m_ph = 0; m_st = M_IDLE;
            e.val = 0; e.run = 1'b0; e.dn = 1'b0;
        end else begin
            hist.push_front(key_n);
            if (hist.size() > DEB + 2) void'(hist.pop_back());
            all_diff = 1'b1;
            for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_deb) all_diff = 1'b0;
            p = m_press;
            m_press = m_fell;
            m_fell = 1'b0;
            if (all_diff) begin
                m_deb = !m_deb;
                m_fell = (m_deb == 1'b0);
            end
            old_st = m_st;
            if (load) begin
                m_st  = M_IDLE;
                m_ph  = 0;
                m_val = clamp9(int'(preset[11:8])) * 100 + clamp9(int'(preset[7:4])) * 10
                        + clamp9(int'(preset[3:0]));
            end else begin
                case (m_st)
                    M_IDLE: if (p) begin
                        m_ph = 0;
                        m_st = (m_val == 0) ? M_DONE : M_RUN;
                    end
                    M_RUN: begin
                        if (m_ph == CNT_MAX) begin
                            m_ph = 0;
                            m_val = m_val - 1;
                            if (p) m_tick_press++;
                            if (m_val == 0) begin
                                m_st = M_DONE;
                                m_zero_hits++;
                            end else if (p) begin
                                m_st = M_PAUSE;
                            end
                        end else begin
                            m_ph++;
                            if (p) m_st = M_PAUSE;
                        end
                    end
                    M_PAUSE: if (p) m_st = M_RUN;
                    M_DONE:  if (p) m_st = M_IDLE;
                    default: m_st = M_IDLE;
                endcase
            end
            e.val = m_val;
            e.run = (old_st == M_RUN);
            e.dn  = (old_st == M_DONE);
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #3;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("digits", {20'd0, bcd_100, bcd_10, bcd_1},
                {20'd0, 4'(e.val / 100), 4'((e.val / 10) % 10), 4'(e.val % 10)});
            chk("running", 32'(running), 32'(e.run));
            chk("done", 32'(done), 32'(e.dn));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] p);
        load = 1'b1;
        preset = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic press_key();
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
    endtask

    task automatic glitch();
        key_n = 1'b0;
        @(negedge clk);
        key_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; load = 1'b0; preset = 12'h000; key_n = 1'b1;
        m_tick_press = 0; m_zero_hits = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(2);

        // async reset while running at 042, then a press from 000 goes to DONE
        do_load(12'h042);
        press_key();
        wait_cycles(8);
        reset_n = 1'b0;
        #1;
        chk("async_reset_digits", {20'd0, bcd_100, bcd_10, bcd_1}, 32'h000);
        chk("async_reset_running", 32'(running), 32'd0);
        chk("async_reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(4);
        press_key();
        wait_cycles(8);
        press_key();
        wait_cycles(8);

        // double borrow from 105
        do_load(12'h105);
        press_key();
        wait_cycles(75);

        // count to zero, hold, then back to idle
        do_load(12'h003);
        press_key();
        wait_cycles(50);
        press_key();
        wait_cycles(8);

        // pause and resume from held prescaler
        do_load(12'h020);
        press_key();
        wait_cycles(15);
        press_key();
        wait_cycles(50);
        press_key();
        wait_cycles(30);

        // sanitized preset, presses ignored under load, short glitch ignored
        load = 1'b1;
        preset = 12'h0AF;
        wait_cycles(2);
        press_key();
        wait_cycles(6);
        glitch();
        wait_cycles(4);
        load = 1'b0;
        wait_cycles(3);
        glitch();
        wait_cycles(10);

        // press coinciding with the first tick
        do_load(12'h002);
        press_key();
        wait_cycles(7);
        press_key();
        wait_cycles(20);
        do_load(12'h001);
        press_key();
        wait_cycles(7);
        press_key();
        wait_cycles(20);

        // full count from 999
        do_load(12'h999);
        press_key();
        n = 0;
        while (!done && n < 10100) begin
            @(negedge clk);
            n++;
        end
        chk("full_count_reached_done", 32'(n < 10100), 32'd1);
        wait_cycles(30);

        // randomized traffic
        repeat (150) begin
            case ($urandom_range(0, 5))
                0: do_load({4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
                1, 2: press_key();
                3: glitch();
                4: begin
                    load = 1'b1;
                    preset = 12'($urandom_range(0, 4095));
                    press_key();
                    load = 1'b0;
                end
                default: ;
            endcase
            wait_cycles($urandom_range(3, 40));
        end

        wait_cycles(5);
        chk("scenario_tick_with_press", 32'(m_tick_press >= 2), 32'd1);
        chk("scenario_reached_zero", 32'(m_zero_hits >= 3), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
